net_tx_sched: RTL

- Round-robin scheduler that shares the single MAC transmit interface (mac_tx_ifc: pktbuf, pktbuf_maxaddr, doorbell, available) between N_REQ packet sources, e.g. the echo responder and a laser-status sender.
- Sequences each grant as request, buffer select, doorbell, wait for transmit start and end, then an inter-frame gap.
- Sits in the net top level between the requesters and mac_tx_ifc; the top level muxes pktbuf arrays using tx_sel.

---
 rtl/net_pkg.sv | 24 ++
 rtl/rr_pick.sv | 34 +++
 rtl/net_tx_sched.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/net_pkg.sv
// net_pkg: shared types and constants for the net transmit path.
//   sched_state_t  - transmit scheduler state encoding
//   ETH_ADDR_W     - width of a packet buffer last-byte address
//   ETH_IFG_CYCLES - inter-frame gap in sys_clk cycles (96 bit-times at 2 bits/cycle)
//   sel_width()    - index width for an N-way select, never less than 1
package net_pkg;

    localparam int unsigned ETH_ADDR_W     = 11;
    localparam int unsigned ETH_IFG_CYCLES = 48;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RING,
        WAIT_START,
        WAIT_DONE,
        GAP
    } sched_state_t;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first set bit of req
// found when scanning upward from index rr, wrapping modulo N_REQ.
//   req   - request vector
//   rr    - index the search starts at (must be < N_REQ)
//   idx   - index of the selected request (0 when none)
//   valid - at least one request is set
module rr_pick #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned SEL_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] rr,
    output logic [SEL_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int unsigned pos;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (32'(rr) + k) % N_REQ;
            // Constant bit selects only; the matching position is found by comparison.
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!valid && (i == pos) && req[i]) begin
                    valid = 1'b1;
                    idx   = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/net_tx_sched.sv
// net_tx_sched: round-robin owner of the single MAC transmit interface.
// Each grant runs SETUP (external pktbuf mux settles), RING (doorbell once the
// MAC is available), WAIT_START / WAIT_DONE (follow tx_available), then GAP.
// Ports:
//   clk, rst            - sys_clk, asynchronous active-high reset
//   req                 - level request per source, held until its done pulse
//   req_maxaddr         - packed last-byte address per source, slice i*ADDR_W
//   grant               - one-hot owner
//   done                - one-cycle pulse on the owner's bit at frame end
//   err                 - one-cycle pulse on the owner's bit on start timeout
//   tx_sel              - owner index, drives the external pktbuf mux
//   tx_pktbuf_maxaddr   - owner's maxaddr, latched at grant
//   tx_doorbell         - doorbell to mac_tx_ifc
//   tx_available        - available from mac_tx_ifc
//   frames_sent         - completed frame count, wraps at 16 bits
// Build option: define NET_TX_SCHED_TIMEOUT_EN to abort a grant when the MAC
// does not start within START_TIMEOUT cycles of the doorbell; otherwise err is
// tied low and WAIT_START waits indefinitely.
module net_tx_sched
    import net_pkg::*;
#(
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned ADDR_W        = ETH_ADDR_W,
    parameter int unsigned IFG_CYCLES    = ETH_IFG_CYCLES,
    parameter int unsigned START_TIMEOUT = 64,
    localparam int unsigned SEL_W        = sel_width(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_maxaddr,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          err,
    output logic [SEL_W-1:0]          tx_sel,
    output logic [ADDR_W-1:0]         tx_pktbuf_maxaddr,
    output logic                      tx_doorbell,
    input  logic                      tx_available,
    output logic [15:0]               frames_sent
);

    localparam int unsigned GAP_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    sched_state_t      state_q, state_d;
    logic [SEL_W-1:0]  rr_q, rr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [N_REQ-1:0]  grant_d, done_d;
    logic [SEL_W-1:0]  sel_d;
    logic [ADDR_W-1:0] addr_d;
    logic              bell_d;
    logic [15:0]       frames_d;

    logic [SEL_W-1:0]  pick_idx;
    logic              pick_valid;

`ifdef NET_TX_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    logic [TO_W-1:0]   to_q, to_d;
    logic [N_REQ-1:0]  err_d;
`else
    // START_TIMEOUT only sizes the optional start-timeout counter.
    logic unused_start_timeout;
    assign unused_start_timeout = (START_TIMEOUT != 0);
    assign err = '0;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (req),
        .rr    (rr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gap_d    = gap_q;
        grant_d  = grant;
        done_d   = '0;
        sel_d    = tx_sel;
        addr_d   = tx_pktbuf_maxaddr;
        bell_d   = 1'b0;
        frames_d = frames_sent;
`ifdef NET_TX_SCHED_TIMEOUT_EN
        err_d    = '0;
        to_d     = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    sel_d             = pick_idx;
                    addr_d            = req_maxaddr[32'(pick_idx)*ADDR_W +: ADDR_W];
                    rr_d              = (32'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
                    state_d           = SETUP;
                end
            end
            SETUP: begin
                state_d = RING;
            end
            RING: begin
                // A source may withdraw before its doorbell; rr stays advanced.
                if (!req[tx_sel]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (tx_available) begin
                    bell_d  = 1'b1;
                    state_d = WAIT_START;
`ifdef NET_TX_SCHED_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end
            WAIT_START: begin
                if (!tx_available) begin
                    state_d = WAIT_DONE;
                end
`ifdef NET_TX_SCHED_TIMEOUT_EN
                else if (to_q == TO_W'(START_TIMEOUT - 1)) begin
                    err_d[tx_sel] = 1'b1;
                    grant_d       = '0;
                    if (IFG_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = GAP_W'(IFG_CYCLES);
                        state_d = GAP;
                    end
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (tx_available) begin
                    done_d[tx_sel] = 1'b1;
                    grant_d        = '0;
                    frames_d       = frames_sent + 16'd1;
                    if (IFG_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = GAP_W'(IFG_CYCLES);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                // Loaded with IFG_CYCLES, so exactly that many cycles are spent here.
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            rr_q              <= '0;
            gap_q             <= '0;
            grant             <= '0;
            done              <= '0;
            tx_sel            <= '0;
            tx_pktbuf_maxaddr <= '0;
            tx_doorbell       <= 1'b0;
            frames_sent       <= '0;
        end else begin
            state_q           <= state_d;
            rr_q              <= rr_d;
            gap_q             <= gap_d;
            grant             <= grant_d;
            done              <= done_d;
            tx_sel            <= sel_d;
            tx_pktbuf_maxaddr <= addr_d;
            tx_doorbell       <= bell_d;
            frames_sent       <= frames_d;
        end
    end

`ifdef NET_TX_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_q <= '0;
            err  <= '0;
        end else begin
            to_q <= to_d;
            err  <= err_d;
        end
    end
`endif

endmodule
